// File: rtl/systolic_mac_pe_pkg.sv
// Shared types and helpers for the systolic MAC processing element.
// Latency: none (types, constants and combinational functions only).
// Backpressure: n/a; psum_hs_t bundles one valid/ready pair of the drain chain.
package systolic_mac_pe_pkg;

  // Internal arithmetic width. Accumulator sums are formed exactly here and
  // then range-checked against the ACC_W limits, so ACC_W may be up to 62.
  localparam int CALC_W = 64;

  typedef logic signed [CALC_W-1:0] calc_t;

  // Result of a limited add: the (possibly clamped) sum and an overflow bit.
  typedef struct packed {
    calc_t sum;
    logic  ovf;
  } add_res_t;

  // One valid/ready handshake of the partial-sum drain chain.
  typedef struct packed {
    logic valid;
    logic ready;
  } psum_hs_t;

  // Largest value representable in an acc_w-bit accumulator.
  function automatic calc_t acc_max(input int acc_w, input bit is_signed);
    calc_t one;
    one = calc_t'(1);
    if (is_signed) return (one <<< (acc_w - 1)) - one;
    return (one <<< acc_w) - one;
  endfunction

  // Smallest value representable in an acc_w-bit accumulator.
  function automatic calc_t acc_min(input int acc_w, input bit is_signed);
    calc_t one;
    one = calc_t'(1);
    if (is_signed) return -(one <<< (acc_w - 1));
    return '0;
  endfunction

  // Adds two values already extended from acc_w bits. Because the sum is
  // exact in CALC_W bits, leaving the acc_w range is the same condition as a
  // sign-rule overflow (signed) or a carry-out (unsigned). When not
  // saturating, the caller truncates the sum to acc_w bits, which wraps.
  function automatic add_res_t sat_add(input calc_t a, input calc_t b,
                                       input int acc_w, input bit is_signed,
                                       input bit saturate);
    add_res_t r;
    calc_t    s;
    calc_t    hi;
    calc_t    lo;
    s     = a + b;
    hi    = acc_max(acc_w, is_signed);
    lo    = acc_min(acc_w, is_signed);
    r.ovf = (s > hi) || (s < lo);
    r.sum = s;
    if (saturate) begin
      if (s > hi)      r.sum = hi;
      else if (s < lo) r.sum = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_mac_pe_drain_stage.sv
// One-entry valid/ready output register; a local result beats upstream data.
// Latency: 1 cycle from accepted local/upstream value to out_valid.
// Backpressure: holds out_data while !out_ready; stalls both sources when full.
module pe_drain_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         loc_valid,
  input  logic [W-1:0] loc_data,
  output logic         loc_take,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic load_ok;

  // The register can accept a new value when empty or being emptied now.
  assign load_ok  = !out_valid || out_ready;
  assign loc_take = load_ok && loc_valid;
  assign up_ready = load_ok && !loc_valid;

  // Load local first, then upstream; otherwise drop valid once consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (loc_take) begin
      out_data  <= loc_data;
      out_valid <= 1'b1;
    end else if (up_ready && up_valid) begin
      out_data  <= up_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic MAC cell: multiply-accumulate tagged runs, forward operands, drain results.
// Latency: operands forwarded in 1 cycle; result on psum_out 2 cycles after last beat.
// Backpressure: in_ready drops while a finished result waits for the drain stage.
module systolic_mac_pe
  import systolic_mac_pe_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] w_out,
  output logic              fwd_valid,
  output logic              fwd_last,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic              psum_in_valid,
  output logic              psum_in_ready,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_out_valid,
  input  logic              psum_out_ready,
  output logic              ovf
);

  logic                       accept;
  logic                       first;
  logic [ACC_W-1:0]           acc;
  logic [ACC_W-1:0]           acc_base;
  logic [ACC_W-1:0]           acc_next;
  logic [ACC_W-1:0]           res_dat;
  logic                       res_full;
  logic                       res_take;
  logic                       up_ready;
  logic signed [DATA_W:0]     x_e;
  logic signed [DATA_W:0]     w_e;
  logic signed [2*DATA_W+1:0] prod_full;
  calc_t                      prod_c;
  calc_t                      acc_c;
  add_res_t                   add_r;
  psum_hs_t                   up_hs;
  psum_hs_t                   dn_hs;

  assign in_ready = !res_full;
  assign accept   = in_valid && in_ready;

  // Extend operands by one bit so a single signed multiplier serves both
  // modes; the product is exact, then widened and added with range checking.
  always_comb begin
    x_e       = (SIGNED != 0) ? $signed({x_in[DATA_W-1], x_in}) : $signed({1'b0, x_in});
    w_e       = (SIGNED != 0) ? $signed({w_in[DATA_W-1], w_in}) : $signed({1'b0, w_in});
    prod_full = x_e * w_e;
    prod_c    = calc_t'(prod_full);
    acc_base  = first ? '0 : acc;
    acc_c     = (SIGNED != 0) ? calc_t'($signed(acc_base)) : calc_t'(acc_base);
    add_r     = sat_add(acc_c, prod_c, ACC_W, SIGNED != 0, SATURATE != 0);
    acc_next  = ACC_W'(add_r.sum);
  end

  // Forward accepted operands to the east/south neighbours one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_out     <= '0;
      w_out     <= '0;
      fwd_valid <= 1'b0;
      fwd_last  <= 1'b0;
    end else begin
      fwd_valid <= accept;
      fwd_last  <= accept && in_last;
      if (accept) begin
        x_out <= x_in;
        w_out <= w_in;
      end
    end
  end

  // Accumulate across a run; the first beat restarts the sum and ovf.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      first <= 1'b1;
      ovf   <= 1'b0;
    end else if (accept) begin
      acc   <= acc_next;
      first <= in_last;
      ovf   <= add_r.ovf || (!first && ovf);
    end
  end

  // Park the finished dot product until the drain stage takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_dat  <= '0;
      res_full <= 1'b0;
    end else if (accept && in_last) begin
      res_dat  <= acc_next;
      res_full <= 1'b1;
    end else if (res_take) begin
      res_full <= 1'b0;
    end
  end

  assign up_hs         = '{valid: psum_in_valid, ready: up_ready};
  assign dn_hs         = '{valid: psum_out_valid, ready: psum_out_ready};
  assign psum_in_ready = up_hs.ready;

  pe_drain_stage #(
    .W(ACC_W)
  ) u_drain (
    .clk       (clk),
    .rst       (rst),
    .loc_valid (res_full),
    .loc_data  (res_dat),
    .loc_take  (res_take),
    .up_valid  (up_hs.valid),
    .up_data   (psum_in),
    .up_ready  (up_ready),
    .out_data  (psum_out),
    .out_valid (psum_out_valid),
    .out_ready (dn_hs.ready)
  );

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Scoreboard bench: four PE configurations share operand buses, each with its own in_valid.
// DUT0 default, DUT1 unsigned, DUT2 16-bit saturating, DUT3 16-bit wrapping.
// A negedge monitor pops expected drain values whenever psum_out transfers.
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  iv = '0;
  logic        last = 1'b0;
  logic [7:0]  x = '0;
  logic [7:0]  w = '0;
  logic [31:0] pin = '0;
  logic        pinv = 1'b0;
  logic        pordy = 1'b1;

  wire  [3:0]  fv, fl, ir, pir, pv, ov;
  wire  [7:0]  xo0, wo0, xo1, wo1, xo2, wo2, xo3, wo3;
  wire  [31:0] po0, po1;
  wire  [15:0] po2, po3;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  systolic_mac_pe u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_last(last),
    .x_in(x), .w_in(w), .x_out(xo0), .w_out(wo0), .fwd_valid(fv[0]), .fwd_last(fl[0]),
    .psum_in(pin), .psum_in_valid(pinv), .psum_in_ready(pir[0]),
    .psum_out(po0), .psum_out_valid(pv[0]), .psum_out_ready(pordy), .ovf(ov[0]));

  systolic_mac_pe #(.SIGNED(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_last(last),
    .x_in(x), .w_in(w), .x_out(xo1), .w_out(wo1), .fwd_valid(fv[1]), .fwd_last(fl[1]),
    .psum_in(32'h0), .psum_in_valid(1'b0), .psum_in_ready(pir[1]),
    .psum_out(po1), .psum_out_valid(pv[1]), .psum_out_ready(pordy), .ovf(ov[1]));

  systolic_mac_pe #(.ACC_W(16), .SATURATE(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_last(last),
    .x_in(x), .w_in(w), .x_out(xo2), .w_out(wo2), .fwd_valid(fv[2]), .fwd_last(fl[2]),
    .psum_in(16'h0), .psum_in_valid(1'b0), .psum_in_ready(pir[2]),
    .psum_out(po2), .psum_out_valid(pv[2]), .psum_out_ready(pordy), .ovf(ov[2]));

  systolic_mac_pe #(.ACC_W(16), .SATURATE(0)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_last(last),
    .x_in(x), .w_in(w), .x_out(xo3), .w_out(wo3), .fwd_valid(fv[3]), .fwd_last(fl[3]),
    .psum_in(16'h0), .psum_in_valid(1'b0), .psum_in_ready(pir[3]),
    .psum_out(po3), .psum_out_valid(pv[3]), .psum_out_ready(pordy), .ovf(ov[3]));

  function automatic logic [31:0] get_po(input int i);
    case (i)
      0:       return po0;
      1:       return po1;
      2:       return {16'h0, po2};
      default: return {16'h0, po3};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errs++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Monitor: every psum_out transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && pordy) begin
      for (int i = 0; i < 4; i++) begin
        if (pv[i]) begin
          if (sb.size() == 0) begin
            timeout("unexpected_psum_out");
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("drain_dut_idx", 32'(i), 32'(e.idx));
            chk("psum_out", get_po(i), e.val);
          end
        end
      end
    end
  end

  // Present one beat to DUT d, wait (bounded) for in_ready, and complete it.
  task automatic beat(input int d, input logic [7:0] xv, input logic [7:0] wv, input logic l);
    bit ok;
    ok = 1'b0;
    x = xv;
    w = wv;
    last = l;
    iv[d] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ir[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("in_ready_wait");
    @(posedge clk);
    #1;
    iv = '0;
    last = 1'b0;
    if (d == 0) begin
      chk("fwd_valid", 32'(fv[0]), 32'd1);
      chk("x_out", 32'(xo0), 32'(xv));
      chk("w_out", 32'(wo0), 32'(wv));
      chk("fwd_last", 32'(fl[0]), 32'(l));
    end
  endtask

  task automatic push(input int d, input logic [31:0] v);
    exp_t e;
    e.idx = 2'(d);
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) timeout("drain_wait");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ir[0]), 32'd1);
    chk("rst_fwd_valid", 32'(fv[0]), 32'd0);
    chk("rst_psum_valid", 32'(pv[0]), 32'd0);
    chk("rst_psum_out", po0, 32'd0);
    chk("rst_x_out", 32'(xo0), 32'd0);
    chk("rst_ovf", 32'(ov[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Forward latency and basic dot product: 12+30+56 = 98
    push(0, 32'd98);
    beat(0, 8'd3, 8'd4, 1'b0);
    beat(0, 8'd5, 8'd6, 1'b0);
    beat(0, 8'd7, 8'd8, 1'b1);
    chk("psum_valid_early", 32'(pv[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("psum_valid_lat", 32'(pv[0]), 32'd1);
    chk("psum_out_lat", po0, 32'd98);
    chk("fwd_valid_idle", 32'(fv[0]), 32'd0);
    chk("x_out_hold", 32'(xo0), 32'd7);
    chk("ovf_basic", 32'(ov[0]), 32'd0);
    wait_drain();

    // Signed: -12 + -10 = -22
    push(0, 32'hFFFF_FFEA);
    beat(0, 8'hFD, 8'h04, 1'b0);
    beat(0, 8'h02, 8'hFB, 1'b1);
    wait_drain();

    // Unsigned, same bit patterns: 1012 + 502 = 1514
    push(1, 32'd1514);
    beat(1, 8'hFD, 8'h04, 1'b0);
    beat(1, 8'h02, 8'hFB, 1'b1);
    wait_drain();

    // 16-bit saturating: 4 x 16129 clamps at 32767
    push(2, 32'h0000_7FFF);
    for (int i = 0; i < 4; i++) beat(2, 8'd127, 8'd127, i == 3);
    wait_drain();
    chk("ovf_sat", 32'(ov[2]), 32'd1);

    // 16-bit wrapping: 64516 mod 65536 = 0xFC04 (-1020)
    push(3, 32'h0000_FC04);
    for (int i = 0; i < 4; i++) beat(3, 8'd127, 8'd127, i == 3);
    wait_drain();
    chk("ovf_wrap", 32'(ov[3]), 32'd1);

    // Back-pressure: fill the output stage and the result buffer
    pordy = 1'b0;
    push(0, 32'd1);
    push(0, 32'd13);
    beat(0, 8'd1, 8'd1, 1'b1);
    beat(0, 8'd2, 8'd2, 1'b0);
    beat(0, 8'd3, 8'd3, 1'b1);
    @(posedge clk);
    #1;
    chk("bp_in_ready", 32'(ir[0]), 32'd0);
    chk("bp_psum_valid", 32'(pv[0]), 32'd1);
    x = 8'h11;
    w = 8'h22;
    iv[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_no_fwd", 32'(fv[0]), 32'd0);
      chk("bp_psum_stable", po0, 32'd1);
      chk("bp_in_ready_low", 32'(ir[0]), 32'd0);
    end
    iv = '0;
    pordy = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (ir[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("bp_in_ready_return");
    wait_drain();

    // Chain priority: local 20 and upstream 55 collide
    push(0, 32'd20);
    push(0, 32'd55);
    beat(0, 8'd4, 8'd5, 1'b1);
    pin = 32'd55;
    pinv = 1'b1;
    #1;
    chk("chain_psum_in_ready_blocked", 32'(pir[0]), 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pir[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("chain_psum_in_ready");
    @(posedge clk);
    #1;
    pinv = 1'b0;
    wait_drain();

    // Reset mid-run discards the partial sum
    beat(0, 8'd9, 8'd9, 1'b0);
    beat(0, 8'd9, 8'd9, 1'b0);
    rst = 1'b0;
    #2;
    chk("mid_rst_fwd_valid", 32'(fv[0]), 32'd0);
    chk("mid_rst_x_out", 32'(xo0), 32'd0);
    chk("mid_rst_w_out", 32'(wo0), 32'd0);
    chk("mid_rst_psum_valid", 32'(pv[0]), 32'd0);
    chk("mid_rst_psum_out", po0, 32'd0);
    chk("mid_rst_in_ready", 32'(ir[0]), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(0, 32'd6);
    beat(0, 8'd2, 8'd3, 1'b1);
    wait_drain();
    chk("post_rst_ovf", 32'(ov[0]), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/systolic_mac_pe.md
Name: systolic_mac_pe

Overview:
- Parametrised successor to the basic systolic MAC processing element.
- Multiplies streaming activation/weight pairs and accumulates them over a tagged dot-product run of K beats.
- Forwards operands east/south one cycle later, and places each finished result on a valid/ready partial-sum drain chain.
- Sits in every cell of the systolic array. The drain chain links the PEs of a column so that results leave the array in order.

Parameters:
- DATA_W, 8, operand width of x and w.
- ACC_W, 32, accumulator and result width; must be at least 2*DATA_W.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- SATURATE, 1, 1 = clamp the accumulator at the ACC_W limits, 0 = wrap modulo 2^ACC_W.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous, active-low reset.
- in_valid, in, 1, operand beat present.
- in_ready, out, 1, PE can accept a beat.
- in_last, in, 1, beat is the final term of the current dot product.
- x_in, in, DATA_W, activation.
- w_in, in, DATA_W, weight.
- x_out, out, DATA_W, registered activation to the neighbour.
- w_out, out, DATA_W, registered weight to the neighbour.
- fwd_valid, out, 1, registered accepted-beat flag.
- fwd_last, out, 1, registered in_last.
- psum_in, in, ACC_W, upstream result.
- psum_in_valid, in, 1, upstream result present.
- psum_in_ready, out, 1, PE takes the upstream result.
- psum_out, out, ACC_W, result to downstream.
- psum_out_valid, out, 1, psum_out is valid.
- psum_out_ready, in, 1, downstream takes psum_out.
- ovf, out, 1, sticky overflow/saturation flag for the current run.

Behaviour:
- **Reset.** While rst=0, all registers clear asynchronously:
  - x_out, w_out, fwd_valid, fwd_last, psum_out, psum_out_valid, ovf, the accumulator and the result buffer are 0.
  - The first-beat flag is set to 1.
  - The result buffer is emptied, so in_ready=1.
- **Accept.** A beat is accepted when in_valid && in_ready, with in_ready = !res_full.
- **Forwarding, 1-cycle latency.**
  - On an accepted beat, x_out/w_out take x_in/w_in, fwd_valid=1 and fwd_last=in_last.
  - Otherwise fwd_valid=0 and fwd_last=0, and x_out/w_out hold their previous values.
- **Product.** prod = x_in*w_in, 2*DATA_W wide.
  - Signed or unsigned per SIGNED.
  - Sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W.
- **Accumulate.**
  - acc_next = (first ? 0 : acc) + prod.
  - Overflow is detected from the operand and result signs (SIGNED=1) or the carry-out (SIGNED=0).
  - On overflow with SATURATE=1, acc_next clamps to the max (or min) of ACC_W and ovf is set.
  - On overflow with SATURATE=0, acc_next wraps and ovf is still set.
  - ovf clears on the first beat of a new run, unless that beat itself overflows.
- **Registered accumulator.** Accumulator state is updated on accepted beats only. first goes to 0 after any accepted non-last beat.
- **Last beat.** On an accepted beat with in_last=1:
  - the result buffer takes acc_next and res_full=1;
  - first=1;
  - in_ready drops in the next cycle.
  - A single-beat run (first && last) yields exactly that beat's product.
- **Drain stage.** psum_out is a one-entry register with a valid/ready handshake.
  - load_ok = !psum_out_valid || psum_out_ready.
  - When load_ok && res_full: psum_out takes the buffer, res_full=0, and psum_out_valid=1.
  - Else when load_ok && psum_in_valid: psum_out takes psum_in and psum_out_valid=1.
  - Else if psum_out_ready: psum_out_valid=0.
  - psum_in_ready = load_ok && !res_full. The local result has priority over upstream data.
  - Upstream data is never dropped or duplicated: a transfer happens only when valid && ready.
- **Latency.** Last beat accepted at edge N: res_full at N, psum_out_valid at N+1 if the stage is free, and in_ready=1 again after N+1.
- **Back-pressure.** If psum_out_ready=0 indefinitely, the result stays buffered, in_ready stays 0, and psum_out stays stable.
- **Reset mid-run.** The partial accumulation and any buffered or in-flight results are discarded. The first beat after reset starts a new run.

Decomposition:
- Shared package holds:
  - accumulator limit constants, derived from ACC_W and SIGNED;
  - a saturating-add function returning the sum and an overflow bit;
  - a psum valid/ready handshake struct.
- One sub-module, pe_drain_stage: the one-entry valid/ready register with the local-priority mux. It is reusable for the array edge collectors.

Test Plan:
- Forward latency, default parameters: beats (3,4),(5,6),(7,8) with last on the third → x_out/w_out/fwd_valid follow one cycle later; psum_out=98 and psum_out_valid two cycles after the last beat; ovf=0.
- Signed arithmetic: (-3,4) then (2,-5) last → result -22 (0xFFFFFFEA). With SIGNED=0, the same bit patterns (253,4),(2,251) → 1514.
- Saturation: ACC_W=16, SIGNED=1, four beats of (127,127) → 32767 with ovf=1. With SATURATE=0 → 64516 mod 65536 = 64516, reported as signed -1020, with ovf=1.
- Back-pressure: hold psum_out_ready=0 and complete a run → in_ready=0; a further in_valid is not accepted, with no fwd_valid pulse; psum_out stays stable; releasing ready drains the value and in_ready returns to 1.
- Chain priority: a local result and psum_in_valid (value 55) arrive in the same cycle → the local result emerges first, 55 next cycle, and psum_in_ready=0 in between.
- Reset mid-run: two beats accepted, rst low for one cycle → all outputs 0; then (2,3) last → result 6, with no stale sum.
